// File: rtl/heq_phase_ctrl.sv
// Phase sequencer for the histogram-equalization engine: runs histogram, CDF and
// divider phases in order, arbitrates scratch memory, captures cdf_min, watchdogs each phase.
module heq_phase_ctrl #(
    parameter int TIMEOUT_W = 20,
    parameter int CYC_W     = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             hist_done,
    input  logic             cdf_min_valid,
    input  logic [31:0]      cdf_min_in,
    input  logic             cdf_done,
    input  logic             div_wt_done,
    output logic             hist_en,
    output logic             cdf_en,
    output logic             div_en,
    output logic [31:0]      cdf_min,
    output logic [1:0]       mem_sel,
    output logic [2:0]       phase,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [1:0]       err_code,
    output logic [CYC_W-1:0] total_cycles
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HIST  = 3'd1,
        S_GAP1  = 3'd2,
        S_CDF   = 3'd3,
        S_GAP2  = 3'd4,
        S_DIV   = 3'd5,
        S_DONE  = 3'd6,
        S_ERROR = 3'd7
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_NOMIN   = 2'd2;

    // Expiry is judged on the value the counter would reach this cycle, so a phase
    // times out after exactly 2^TIMEOUT_W-1 cycles.
    localparam logic [TIMEOUT_W-1:0] WD_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    state_t               state_q, state_d;
    logic [1:0]           err_code_q, err_code_d;
    logic [TIMEOUT_W-1:0] wd_q;
    logic [31:0]          cdf_min_q;
    logic                 min_seen_q;
    logic [CYC_W-1:0]     total_q;

    logic wd_expire;
    logic wd_counting;
    logic busy_state;
    logic enter_hist;

    assign wd_expire   = (wd_q == WD_LAST);
    assign wd_counting = (state_q == S_HIST) || (state_q == S_CDF) || (state_q == S_DIV);
    assign busy_state  = (state_q >= S_HIST) && (state_q <= S_DIV);
    assign enter_hist  = (state_d == S_HIST) && (state_q != S_HIST);

    always_comb begin
        state_d    = state_q;
        err_code_d = err_code_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_ERROR: begin
                    if (start) begin
                        state_d    = S_HIST;
                        err_code_d = ERR_NONE;
                    end
                end
                S_HIST: begin
                    if (hist_done) begin
                        state_d = S_GAP1;
                    end else if (wd_expire) begin
                        state_d    = S_ERROR;
                        err_code_d = ERR_TIMEOUT;
                    end
                end
                S_GAP1: state_d = S_CDF;
                S_CDF: begin
                    // A valid arriving in the same cycle as cdf_done still counts.
                    if (cdf_done) begin
                        if (min_seen_q || cdf_min_valid) begin
                            state_d = S_GAP2;
                        end else begin
                            state_d    = S_ERROR;
                            err_code_d = ERR_NOMIN;
                        end
                    end else if (wd_expire) begin
                        state_d    = S_ERROR;
                        err_code_d = ERR_TIMEOUT;
                    end
                end
                S_GAP2: state_d = S_DIV;
                S_DIV: begin
                    if (div_wt_done) begin
                        state_d = S_DONE;
                    end else if (wd_expire) begin
                        state_d    = S_ERROR;
                        err_code_d = ERR_TIMEOUT;
                    end
                end
                S_DONE: begin
                    if (start) begin
                        state_d    = S_HIST;
                        err_code_d = ERR_NONE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            err_code_q <= ERR_NONE;
            wd_q       <= '0;
            cdf_min_q  <= '0;
            min_seen_q <= 1'b0;
            total_q    <= '0;
        end else begin
            state_q    <= state_d;
            err_code_q <= err_code_d;

            if (state_d != state_q) begin
                wd_q <= '0;
            end else if (wd_counting) begin
                wd_q <= wd_q + 1'b1;
            end

            if (enter_hist) begin
                cdf_min_q  <= '0;
                min_seen_q <= 1'b0;
                total_q    <= '0;
            end else begin
                if ((state_q == S_CDF) && cdf_min_valid && !min_seen_q && !abort) begin
                    cdf_min_q  <= cdf_min_in;
                    min_seen_q <= 1'b1;
                end
                if (busy_state && (total_q != '1)) begin
                    total_q <= total_q + 1'b1;
                end
            end
        end
    end

    assign hist_en      = (state_q == S_HIST);
    assign cdf_en       = (state_q == S_CDF);
    assign div_en       = (state_q == S_DIV);
    assign mem_sel      = hist_en ? 2'd1 : (cdf_en ? 2'd2 : (div_en ? 2'd3 : 2'd0));
    assign phase        = state_q;
    assign busy         = busy_state;
    assign done         = (state_q == S_DONE);
    assign error        = (state_q == S_ERROR);
    assign err_code     = err_code_q;
    assign cdf_min      = cdf_min_q;
    assign total_cycles = total_q;

endmodule

// File: tb/tb_heq_phase_ctrl.sv
// Directed bench for heq_phase_ctrl: nominal run, missing minimum, watchdog,
// abort, multiple valids and asynchronous reset, checked with immediate assertions.
module tb_heq_phase_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        hist_done = 1'b0;
    logic        cdf_min_valid = 1'b0;
    logic [31:0] cdf_min_in = 32'd0;
    logic        cdf_done = 1'b0;
    logic        div_wt_done = 1'b0;

    logic        hist_en, cdf_en, div_en, busy, done, error;
    logic [31:0] cdf_min, total_cycles;
    logic [1:0]  mem_sel, err_code;
    logic [2:0]  phase;

    logic        w_hist_en, w_cdf_en, w_div_en, w_busy, w_done, w_error;
    logic [31:0] w_cdf_min, w_total_cycles;
    logic [1:0]  w_mem_sel, w_err_code;
    logic [2:0]  w_phase;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    heq_phase_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .hist_done(hist_done), .cdf_min_valid(cdf_min_valid), .cdf_min_in(cdf_min_in),
        .cdf_done(cdf_done), .div_wt_done(div_wt_done),
        .hist_en(hist_en), .cdf_en(cdf_en), .div_en(div_en), .cdf_min(cdf_min),
        .mem_sel(mem_sel), .phase(phase), .busy(busy), .done(done), .error(error),
        .err_code(err_code), .total_cycles(total_cycles)
    );

    heq_phase_ctrl #(.TIMEOUT_W(4)) dut_wd (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .hist_done(hist_done), .cdf_min_valid(cdf_min_valid), .cdf_min_in(cdf_min_in),
        .cdf_done(cdf_done), .div_wt_done(div_wt_done),
        .hist_en(w_hist_en), .cdf_en(w_cdf_en), .div_en(w_div_en), .cdf_min(w_cdf_min),
        .mem_sel(w_mem_sel), .phase(w_phase), .busy(w_busy), .done(w_done), .error(w_error),
        .err_code(w_err_code), .total_cycles(w_total_cycles)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // No cycle may ever have more than one phase enable high.
    always @(negedge clk) begin
        if (reset) chk("one_enable", 64'($onehot0({hist_en, cdf_en, div_en})), 64'd1);
    end

    initial begin
        // Reset state
        #3;
        chk("rst_phase", 64'(phase), 64'd0);
        chk("rst_outs", 64'({hist_en, cdf_en, div_en, busy, done, error}), 64'd0);
        chk("rst_misc", 64'({mem_sel, err_code}), 64'd0);
        chk("rst_cdfmin", 64'(cdf_min), 64'd0);
        chk("rst_total", 64'(total_cycles), 64'd0);
        tick(2);
        reset = 1'b1;
        tick();

        // Nominal run: HIST 10, CDF 20, DIV 30 cycles
        start = 1'b1; tick(); start = 1'b0;
        chk("nom_hist_phase", 64'(phase), 64'd1);
        chk("nom_hist_en", 64'({hist_en, mem_sel, busy}), 64'b1_01_1);
        tick(9);
        hist_done = 1'b1; tick(); hist_done = 1'b0;
        chk("nom_gap1", 64'({phase, hist_en, cdf_en, mem_sel}), {59'd0, 3'd2, 2'b00} << 2);
        tick();
        chk("nom_cdf", 64'({phase, cdf_en, mem_sel}), {58'd0, 3'd3, 1'b1, 2'd2});
        cdf_min_valid = 1'b1; cdf_min_in = 32'h5; tick(); cdf_min_valid = 1'b0;
        tick(18);
        cdf_done = 1'b1; tick(); cdf_done = 1'b0;
        chk("nom_gap2", 64'({phase, cdf_en, div_en}), {59'd0, 3'd4, 2'b00});
        chk("nom_gap2_min", 64'(cdf_min), 64'd5);
        tick();
        chk("nom_div", 64'({phase, div_en, mem_sel}), {58'd0, 3'd5, 1'b1, 2'd3});
        chk("nom_div_min", 64'(cdf_min), 64'd5);
        tick(29);
        chk("nom_div_last", 64'({busy, done}), 64'b10);
        div_wt_done = 1'b1; tick(); div_wt_done = 1'b0;
        chk("nom_done", 64'({phase, done, busy, div_en}), {58'd0, 3'd6, 3'b100});
        chk("nom_total", 64'(total_cycles), 64'd62);
        tick();
        chk("nom_after", 64'({phase, done}), 64'd0);
        chk("nom_total_hold", 64'(total_cycles), 64'd62);

        // Missing minimum
        start = 1'b1; tick(); start = 1'b0;
        hist_done = 1'b1; tick(); hist_done = 1'b0;
        tick();
        chk("nomin_cdf", 64'(phase), 64'd3);
        cdf_done = 1'b1; tick(); cdf_done = 1'b0;
        chk("nomin_err", 64'({phase, error, err_code, div_en}), {58'd0, 3'd7, 1'b1, 2'd2, 1'b0});
        tick(3);
        chk("nomin_sticky", 64'({error, err_code, div_en}), {60'd0, 1'b1, 2'd2, 1'b0});
        start = 1'b1; tick(); start = 1'b0;
        chk("nomin_restart", 64'({phase, error, err_code}), {58'd0, 3'd1, 1'b0, 2'd0});
        chk("nomin_min_clr", 64'(cdf_min), 64'd0);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("abort_idle", 64'(phase), 64'd0);

        // Watchdog on the TIMEOUT_W=4 instance
        start = 1'b1; tick(); start = 1'b0;
        tick(14);
        chk("wd_hist15", 64'({w_phase, w_hist_en}), {60'd0, 3'd1, 1'b1});
        tick();
        chk("wd_err", 64'({w_phase, w_error, w_err_code, w_hist_en}), {58'd0, 3'd7, 1'b1, 2'd1, 1'b0});
        chk("wd_wide_still", 64'(phase), 64'd1);
        abort = 1'b1; tick(); abort = 1'b0;

        // Same-cycle valid/done, start ignored while busy, abort in DIV
        start = 1'b1; tick(); start = 1'b0;
        hist_done = 1'b1; tick(); hist_done = 1'b0;
        tick();
        start = 1'b1; tick(); start = 1'b0;
        chk("busy_start_ign", 64'(phase), 64'd3);
        cdf_min_valid = 1'b1; cdf_min_in = 32'h9; cdf_done = 1'b1; tick();
        cdf_min_valid = 1'b0; cdf_done = 1'b0;
        chk("same_cyc_gap2", 64'({phase, error}), {60'd0, 3'd4, 1'b0});
        chk("same_cyc_min", 64'(cdf_min), 64'd9);
        tick();
        abort = 1'b1; div_wt_done = 1'b1; tick(); abort = 1'b0; div_wt_done = 1'b0;
        chk("abort_div", 64'({phase, done, div_en}), 64'd0);
        chk("abort_min_hold", 64'(cdf_min), 64'd9);
        tick();
        chk("abort_no_done", 64'({phase, done}), 64'd0);

        // Multiple valids: first one wins; DONE with start goes straight to HIST
        start = 1'b1; tick(); start = 1'b0;
        hist_done = 1'b1; tick(); hist_done = 1'b0;
        tick();
        cdf_min_valid = 1'b1; cdf_min_in = 32'h7; tick();
        cdf_min_in = 32'h3; tick();
        cdf_min_valid = 1'b0; cdf_done = 1'b1; tick(); cdf_done = 1'b0;
        chk("multi_min", 64'(cdf_min), 64'd7);
        tick();
        div_wt_done = 1'b1; tick(); div_wt_done = 1'b0;
        chk("multi_done", 64'({phase, done}), {60'd0, 3'd6, 1'b1});
        chk("multi_total", 64'(total_cycles), 64'd7);
        start = 1'b1; tick(); start = 1'b0;
        chk("done_to_hist", 64'({phase, hist_en, done}), {59'd0, 3'd1, 2'b10});
        chk("done_to_hist_clr", 64'({cdf_min, total_cycles}), 64'd0);

        // Asynchronous reset while in CDF
        hist_done = 1'b1; tick(); hist_done = 1'b0;
        tick();
        cdf_min_valid = 1'b1; cdf_min_in = 32'hA; tick(); cdf_min_valid = 1'b0;
        chk("pre_rst_cdf", 64'({phase, cdf_min}), {29'd0, 3'd3, 32'hA});
        #2 reset = 1'b0;
        #1;
        chk("arst_outs", 64'({phase, hist_en, cdf_en, div_en, busy, done, error, mem_sel, err_code}), 64'd0);
        chk("arst_vals", 64'({cdf_min, total_cycles}), 64'd0);
        tick();
        #2 reset = 1'b1;
        tick();
        start = 1'b1; tick(); start = 1'b0;
        chk("post_rst_hist", 64'({phase, hist_en, mem_sel}), {58'd0, 3'd1, 1'b1, 2'd1});
        hist_done = 1'b1; tick(); hist_done = 1'b0;
        chk("post_rst_gap1", 64'(phase), 64'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/heq_phase_ctrl.md
# heq_phase_ctrl

Phase sequencer for the histogram-equalization engine. It runs the three scratch-memory phases in fixed order: histogram build, CDF accumulation, then the divider array. It hands scratch-memory ownership to one phase at a time, captures `cdf_min` for the divider cores and guards every phase with a watchdog. It sits above the histogram, CDF and divider top-level blocks and drives their enables.

## Interface
Parameters:
- `TIMEOUT_W`, 20: width of the per-phase watchdog counter; timeout fires at 2^TIMEOUT_W−1 cycles in one phase.
- `CYC_W`, 32: width of the total-cycle counter.

Ports:
- `clk` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: request a run; sampled only in IDLE, DONE or ERROR.
- `abort` in 1: return to IDLE from any state.
- `hist_done` in 1: histogram phase finished (level or pulse).
- `cdf_min_valid` in 1: `cdf_min_in` carries the minimum non-zero CDF value.
- `cdf_min_in` in 32: CDF minimum from the CDF block.
- `cdf_done` in 1: CDF phase finished.
- `div_wt_done` in 1: divider write-back finished (the divider block's `div_sc_mem_wt_done`).
- `hist_en` out 1: histogram block enable.
- `cdf_en` out 1: CDF block enable.
- `div_en` out 1: divider block `enable`.
- `cdf_min` out 32: registered CDF minimum, fed to all divider cores.
- `mem_sel` out 2: scratch-memory owner; 0 none, 1 hist, 2 cdf, 3 div.
- `phase` out 3: encoded state (encoding below).
- `busy` out 1: high in HIST, GAP1, CDF, GAP2 and DIV.
- `done` out 1: one-cycle pulse on successful completion.
- `error` out 1: high in ERROR.
- `err_code` out 2: 0 none, 1 timeout, 2 no cdf_min.
- `total_cycles` out CYC_W: cycles from HIST entry to DONE; saturating.

## Operation
State encoding (`phase`): IDLE=0, HIST=1, GAP1=2, CDF=3, GAP2=4, DIV=5, DONE=6, ERROR=7.

Outputs are Moore-decoded from registered state, or registered directly:
- `hist_en`/`mem_sel`=1 in HIST only.
- `cdf_en`/`mem_sel`=2 in CDF only.
- `div_en`/`mem_sel`=3 in DIV only.
- All enables are 0 and `mem_sel`=0 in every other state.

Transitions:
- IDLE/DONE/ERROR: `start` → HIST. Entering HIST clears `cdf_min`, the min-captured flag, `err_code` and `total_cycles`.
- HIST: `hist_done` → GAP1.
- GAP1: exactly one turnaround cycle, then → CDF.
- CDF:
  - First cycle with `cdf_min_valid`=1 loads `cdf_min` and sets the captured flag; later valids are ignored.
  - `cdf_done` with flag set (including a same-cycle valid) → GAP2.
  - `cdf_done` with flag clear → ERROR, `err_code`=2.
- GAP2: one cycle, then → DIV.
- DIV: `div_wt_done` → DONE.
- DONE: one cycle with `done`=1; then → IDLE, or → HIST if `start` is high.
- ERROR: sticky until `start` (→ HIST) or `abort` (→ IDLE, `err_code` held).

Watchdog:
- Counter clears on every state entry and increments each cycle in HIST, CDF and DIV.
- At all-ones, with no done in that cycle → ERROR, `err_code`=1.

Priority each cycle: `abort` > phase done > timeout.
- `abort` in any state → IDLE; no `done`; `cdf_min` holds.
- `start` while busy is ignored.

`total_cycles`:
- Increments every cycle in states 1–5; saturates at all-ones.
- Holds its value in DONE, ERROR and IDLE.

Reset values: state IDLE; all enables 0; `mem_sel` 0; `cdf_min` 0; `done` 0; `error` 0; `err_code` 0; `total_cycles` 0; `busy` 0; `phase` 0.

## Timing
- `start` sampled high at edge N → state HIST from edge N, so `hist_en`=1 in the cycle after N. One-cycle start latency.
- Phase done sampled at edge M → that phase's enable is low from M. The next phase's enable rises at M+1 (one gap cycle). No cycle ever has two enables high.
- `div_wt_done` at edge M → `done`=1 for the cycle after M only; `busy` falls at M.
- `cdf_min` is stable before `div_en` rises and is never modified during GAP2 or DIV.
- Asserting `reset` mid-run drops all outputs to reset values immediately (asynchronous).
- `total_cycles` equals (HIST cycles)+(CDF cycles)+(DIV cycles)+2.

## Test plan
- Nominal run: start; hist_done 10 cycles after `hist_en`; cdf_min_valid with 0x0000_0005, then cdf_done after 20; div_wt_done after 30. Required: enables strictly sequential with 1-cycle gaps, `cdf_min`=5 during DIV, single `done` pulse, `total_cycles`=62.
- Missing minimum: cdf_done with no cdf_min_valid → `error`=1, `err_code`=2, `div_en` never rises. Then start → HIST, `err_code`=0.
- Watchdog: TIMEOUT_W=4, hist_done never asserted → ERROR after 15 HIST cycles, `err_code`=1, `hist_en` low.
- Abort in DIV together with div_wt_done → IDLE, no `done`, `div_en` low next cycle. Start pulses while busy are ignored.
- Multiple valids: cdf_min_valid with 7 then 3 → `cdf_min`=7. Valid coinciding with cdf_done → GAP2 with that value captured.
- Reset asserted in CDF → all outputs 0 asynchronously. After release, start runs normally from HIST.
